// File: rtl/inst_fetch_if.sv
// Instruction ROM bus between the fetch unit (master) and the ROM (slave).
// The ROM answers combinationally: inst_i belongs to the pc_o of the same cycle.
interface inst_fetch_if;
  logic        ce_o;
  logic [31:0] pc_o;
  logic [31:0] inst_i;

  modport master (output ce_o, output pc_o, input inst_i);
  modport slave  (input ce_o, input pc_o, output inst_i);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the ROM address/chip-enable and registers
// the returned word with its PC as the IF/ID payload.
// Optional misaligned-redirect trap is enabled with `define FETCH_ALIGN_CHK_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [31:0]         new_pc_i,
  input  logic                branch_flag_i,
  input  logic [31:0]         branch_target_i,
  inst_fetch_if.master        rom,
  output logic [31:0]         if_pc_o,
  output logic [31:0]         if_inst_o,
  output logic                if_valid_o,
  output logic [31:0]         fetch_cnt_o,
  output logic                align_exc_o
);

`ifdef FETCH_ALIGN_CHK_EN
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2, TRAP = 2'd3} state_t;

  // A redirect target is legal only when it is word aligned.
  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction
`else
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic        ce_q, ce_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] cnt_q, cnt_d;
`ifdef FETCH_ALIGN_CHK_EN
  logic        exc_q, exc_d;
`endif

  // Next-state and next-payload selection; priority flush > stall > branch > sequential.
  always_comb begin
    state_d    = state_q;
    ce_d       = ce_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    cnt_d      = cnt_q;
`ifdef FETCH_ALIGN_CHK_EN
    exc_d      = exc_q;
`endif
    case (state_q)
      BOOT: begin
        // flush is deliberately ignored here: the first fetch is always RESET_PC
        ce_d    = 1'b1;
        pc_d    = RESET_PC;
        state_d = RUN;
      end
      RUN, HOLD: begin
        if (flush_i) begin
`ifdef FETCH_ALIGN_CHK_EN
          if (misaligned(new_pc_i)) begin
            if_valid_d = 1'b0;
            exc_d      = 1'b1;
            ce_d       = 1'b0;
            state_d    = TRAP;
          end else
`endif
          begin
            pc_d       = new_pc_i;
            if_pc_d    = 32'h0000_0000;
            if_inst_d  = 32'h0000_0000;
            if_valid_d = 1'b0;
            state_d    = RUN;
          end
        end else if (stall_i) begin
          // same address stays on the bus, payload and count frozen
          state_d = HOLD;
        end else begin
          // the current word is delivered to ID (also the branch delay slot)
          if_pc_d    = pc_q;
          if_inst_d  = rom.inst_i;
          if_valid_d = 1'b1;
          cnt_d      = cnt_q + 32'd1;
          state_d    = RUN;
          if (branch_flag_i) begin
`ifdef FETCH_ALIGN_CHK_EN
            if (misaligned(branch_target_i)) begin
              // trapping redirect: nothing is delivered, PC stays put
              if_pc_d    = if_pc_q;
              if_inst_d  = if_inst_q;
              if_valid_d = 1'b0;
              cnt_d      = cnt_q;
              exc_d      = 1'b1;
              ce_d       = 1'b0;
              state_d    = TRAP;
            end else
`endif
            begin
              pc_d = branch_target_i;
            end
          end else begin
            // sequential increment is never alignment checked; wraps modulo 2^32
            pc_d = pc_q + PC_STEP;
          end
        end
      end
`ifdef FETCH_ALIGN_CHK_EN
      TRAP: begin
        if (flush_i && !misaligned(new_pc_i)) begin
          exc_d   = 1'b0;
          ce_d    = 1'b1;
          pc_d    = new_pc_i;
          state_d = RUN;
        end else begin
          state_d = TRAP;
        end
      end
`endif
      default: begin
        state_d    = BOOT;
        ce_d       = 1'b0;
        pc_d       = RESET_PC;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      ce_q       <= 1'b0;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= 32'h0000_0000;
      if_valid_q <= 1'b0;
      cnt_q      <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHK_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ce_q       <= ce_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      cnt_q      <= cnt_d;
`ifdef FETCH_ALIGN_CHK_EN
      exc_q      <= exc_d;
`endif
    end
  end

  assign rom.ce_o    = ce_q;
  assign rom.pc_o    = pc_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign if_valid_o  = if_valid_q;
  assign fetch_cnt_o = cnt_q;
`ifdef FETCH_ALIGN_CHK_EN
  assign align_exc_o = exc_q;
`else
  assign align_exc_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the fetch rules.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = 32'h0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [31:0] if_pc_o, if_inst_o, fetch_cnt_o;
  logic        if_valid_o, align_exc_o;

  int total = 0;
  int bad   = 0;

  inst_fetch_if rom_bus ();

  inst_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i), .rom(rom_bus),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o),
    .fetch_cnt_o(fetch_cnt_o), .align_exc_o(align_exc_o)
  );

  always #5 clk = ~clk;

  // ROM contents: a scrambled function of the address
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign rom_bus.inst_i = rom_word(rom_bus.pc_o);

`ifdef FETCH_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // behavioural model: "booting" and "trapped" flags; running/holding behave identically
  logic        m_boot = 1'b1, m_trap = 1'b0, m_ce = 1'b0, m_valid = 1'b0, m_exc = 1'b0;
  logic [31:0] m_pc = 32'h0, m_if_pc = 32'h0, m_if_inst = 32'h0, m_cnt = 32'h0;

  task automatic cycle(input logic r, input logic s, input logic f, input logic b,
                       input logic [31:0] tgt, input logic [31:0] npc);
    @(negedge clk);
    rst = r; stall_i = s; flush_i = f; branch_flag_i = b; branch_target_i = tgt; new_pc_i = npc;
    if (r) begin
      m_boot = 1'b1; m_trap = 1'b0; m_ce = 1'b0; m_pc = 32'h0; m_if_pc = 32'h0;
      m_if_inst = 32'h0; m_valid = 1'b0; m_cnt = 32'h0; m_exc = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_ce = 1'b1; m_pc = 32'h0;
    end else if (m_trap) begin
      if (f && npc[1:0] == 2'b00) begin
        m_trap = 1'b0; m_exc = 1'b0; m_ce = 1'b1; m_pc = npc;
      end
    end else if (f) begin
      if (CHK && npc[1:0] != 2'b00) begin
        m_trap = 1'b1; m_exc = 1'b1; m_ce = 1'b0; m_valid = 1'b0;
      end else begin
        m_pc = npc; m_valid = 1'b0; m_if_inst = 32'h0; m_if_pc = 32'h0;
      end
    end else if (!s) begin
      if (b && CHK && tgt[1:0] != 2'b00) begin
        m_trap = 1'b1; m_exc = 1'b1; m_ce = 1'b0; m_valid = 1'b0;
      end else begin
        m_if_pc = m_pc; m_if_inst = rom_word(m_pc); m_valid = 1'b1; m_cnt = m_cnt + 1;
        m_pc = b ? tgt : m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80);
    total++; if (rom_bus.ce_o !== 1'b0) begin bad++; $display("FAIL reset_ce got=%0h exp=0", rom_bus.ce_o); end
    total++; if (rom_bus.pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", rom_bus.pc_o); end
    total++; if ({if_valid_o, if_pc_o, if_inst_o, fetch_cnt_o, align_exc_o} !== 98'h0) begin
      bad++; $display("FAIL reset_payload got v=%0h pc=%h inst=%h cnt=%h exc=%0h exp all 0",
                      if_valid_o, if_pc_o, if_inst_o, fetch_cnt_o, align_exc_o); end
  endtask

  task automatic test_sequential();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (rom_bus.ce_o !== 1'b1 || rom_bus.pc_o !== 32'h0 || fetch_cnt_o !== 32'd0 || if_valid_o !== 1'b0) begin
      bad++; $display("FAIL boot_exit got ce=%0h pc=%h cnt=%0d v=%0h exp ce=1 pc=0 cnt=0 v=0",
                      rom_bus.ce_o, rom_bus.pc_o, fetch_cnt_o, if_valid_o); end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      total++;
      if (rom_bus.pc_o !== 32'(4*(k+1)) || if_pc_o !== 32'(4*k) || fetch_cnt_o !== 32'(k+1) ||
          if_inst_o !== rom_word(32'(4*k)) || if_valid_o !== 1'b1) begin
        bad++; $display("FAIL seq_%0d got pc=%h if_pc=%h cnt=%0d inst=%h v=%0h exp pc=%h if_pc=%h cnt=%0d inst=%h v=1",
                        k, rom_bus.pc_o, if_pc_o, fetch_cnt_o, if_inst_o, if_valid_o,
                        32'(4*(k+1)), 32'(4*k), k+1, rom_word(32'(4*k))); end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      total++;
      if (rom_bus.pc_o !== 32'h10 || if_pc_o !== 32'hC || fetch_cnt_o !== 32'd4 || rom_bus.ce_o !== 1'b1) begin
        bad++; $display("FAIL stall_%0d got pc=%h if_pc=%h cnt=%0d ce=%0h exp pc=10 if_pc=c cnt=4 ce=1",
                        k, rom_bus.pc_o, if_pc_o, fetch_cnt_o, rom_bus.ce_o); end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (rom_bus.pc_o !== 32'h14 || if_pc_o !== 32'h10 || fetch_cnt_o !== 32'd5) begin
      bad++; $display("FAIL stall_release got pc=%h if_pc=%h cnt=%0d exp pc=14 if_pc=10 cnt=5",
                      rom_bus.pc_o, if_pc_o, fetch_cnt_o); end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (rom_bus.pc_o !== 32'h20) begin bad++; $display("FAIL br_setup got pc=%h exp 20", rom_bus.pc_o); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    total++; if (rom_bus.pc_o !== 32'h100 || if_pc_o !== 32'h20 || if_valid_o !== 1'b1 || fetch_cnt_o !== 32'd9) begin
      bad++; $display("FAIL br_slot got pc=%h if_pc=%h v=%0h cnt=%0d exp pc=100 if_pc=20 v=1 cnt=9",
                      rom_bus.pc_o, if_pc_o, if_valid_o, fetch_cnt_o); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (rom_bus.pc_o !== 32'h104 || if_pc_o !== 32'h100 || if_inst_o !== rom_word(32'h100)) begin
      bad++; $display("FAIL br_target got pc=%h if_pc=%h inst=%h exp pc=104 if_pc=100 inst=%h",
                      rom_bus.pc_o, if_pc_o, if_inst_o, rom_word(32'h100)); end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h180);
    total++; if (rom_bus.pc_o !== 32'h180 || if_valid_o !== 1'b0 || if_pc_o !== 32'h0 ||
                 if_inst_o !== 32'h0 || fetch_cnt_o !== 32'd10) begin
      bad++; $display("FAIL flush got pc=%h v=%0h if_pc=%h inst=%h cnt=%0d exp pc=180 v=0 if_pc=0 inst=0 cnt=10",
                      rom_bus.pc_o, if_valid_o, if_pc_o, if_inst_o, fetch_cnt_o); end
  endtask

  task automatic test_pc_wrap();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (rom_bus.pc_o !== 32'h0 || if_pc_o !== 32'hFFFF_FFFC || fetch_cnt_o !== 32'd11) begin
      bad++; $display("FAIL pc_wrap got pc=%h if_pc=%h cnt=%0d exp pc=0 if_pc=fffffffc cnt=11",
                      rom_bus.pc_o, if_pc_o, fetch_cnt_o); end
  endtask

  task automatic test_align();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h102, 32'h0);
`ifdef FETCH_ALIGN_CHK_EN
    total++; if (align_exc_o !== 1'b1 || rom_bus.ce_o !== 1'b0 || rom_bus.pc_o !== 32'h0 ||
                 if_valid_o !== 1'b0 || fetch_cnt_o !== 32'd11) begin
      bad++; $display("FAIL align_trap got exc=%0h ce=%0h pc=%h v=%0h cnt=%0d exp exc=1 ce=0 pc=0 v=0 cnt=11",
                      align_exc_o, rom_bus.ce_o, rom_bus.pc_o, if_valid_o, fetch_cnt_o); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h181);
    total++; if (align_exc_o !== 1'b1 || rom_bus.ce_o !== 1'b0) begin
      bad++; $display("FAIL align_stay got exc=%0h ce=%0h exp exc=1 ce=0", align_exc_o, rom_bus.ce_o); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h180);
    total++; if (align_exc_o !== 1'b0 || rom_bus.ce_o !== 1'b1 || rom_bus.pc_o !== 32'h180) begin
      bad++; $display("FAIL align_exit got exc=%0h ce=%0h pc=%h exp exc=0 ce=1 pc=180",
                      align_exc_o, rom_bus.ce_o, rom_bus.pc_o); end
`else
    total++; if (align_exc_o !== 1'b0 || rom_bus.pc_o !== 32'h102 || if_valid_o !== 1'b1 || fetch_cnt_o !== 32'd12) begin
      bad++; $display("FAIL align_nochk got exc=%0h pc=%h v=%0h cnt=%0d exp exc=0 pc=102 v=1 cnt=12",
                      align_exc_o, rom_bus.pc_o, if_valid_o, fetch_cnt_o); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h180);
    total++; if (rom_bus.pc_o !== 32'h180 || rom_bus.ce_o !== 1'b1) begin
      bad++; $display("FAIL align_flush got pc=%h ce=%0h exp pc=180 ce=1", rom_bus.pc_o, rom_bus.ce_o); end
`endif
  endtask

  task automatic test_random();
    logic r, s, f, b;
    logic [31:0] tgt, npc;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(63) == 0);
      s   = ($urandom_range(3) == 0);
      f   = ($urandom_range(9) == 0);
      b   = ($urandom_range(4) == 0);
      tgt = {20'h0, $urandom_range(4095) > 0 ? 12'($urandom) : 12'hFFC};
      npc = $urandom;
      if ($urandom_range(7) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(7) != 0) npc[1:0] = 2'b00;
      if ($urandom_range(31) == 0) npc = 32'hFFFF_FFF8;
      cycle(r, s, f, b, tgt, npc);
      total++;
      if (rom_bus.ce_o !== m_ce || rom_bus.pc_o !== m_pc || if_pc_o !== m_if_pc || if_inst_o !== m_if_inst ||
          if_valid_o !== m_valid || fetch_cnt_o !== m_cnt || align_exc_o !== m_exc) begin
        bad++;
        $display("FAIL rand_%0d got ce=%0h pc=%h ifpc=%h inst=%h v=%0h cnt=%h exc=%0h exp ce=%0h pc=%h ifpc=%h inst=%h v=%0h cnt=%h exc=%0h",
                 n, rom_bus.ce_o, rom_bus.pc_o, if_pc_o, if_inst_o, if_valid_o, fetch_cnt_o, align_exc_o,
                 m_ce, m_pc, m_if_pc, m_if_inst, m_valid, m_cnt, m_exc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_flush();
    test_pc_wrap();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch-side initiator for the instruction ROM.
- Generates the word-aligned fetch address and chip-enable the ROM consumes.
- Samples the ROM's combinational instruction word and presents it, with its PC, as the registered IF/ID payload to decode.
- Sits between pipeline control (stall/flush from ctrl, branch redirect from ID) and the ROM.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- stall_i  input  1  downstream stall; hold PC and IF/ID payload
- flush_i  input  1  pipeline flush (exception/eret); redirect to new_pc_i
- new_pc_i  input  32  flush target address
- branch_flag_i  input  1  taken branch/jump from ID
- branch_target_i  input  32  branch target address
- inst_i  input  32  instruction word returned by ROM for pc_o (same cycle)
- ce_o  output  1  ROM chip-enable
- pc_o  output  32  ROM fetch address
- if_pc_o  output  32  PC of instruction presented to ID
- if_inst_o  output  32  instruction presented to ID
- if_valid_o  output  1  if_inst_o holds a real fetched instruction
- fetch_cnt_o  output  32  count of instructions delivered to ID
- align_exc_o  output  1  misaligned redirect trap (see Optional Feature)

Behaviour:
- Reset: one clock, clk; synchronous, active-high reset, rst; all state updates on rising edge of clk.
- Reset values: ce_o=0, pc_o=RESET_PC, if_pc_o=0, if_inst_o=0, if_valid_o=0, fetch_cnt_o=0, align_exc_o=0, state=BOOT.
- All outputs registered; ROM responds combinationally, so inst_i is valid in the same cycle pc_o/ce_o are presented.
- States:
  - BOOT: ce_o=0. Next edge with rst=0: ce_o<=1, pc_o stays RESET_PC -> RUN.
  - RUN: ce_o=1. Each edge, first applicable action in priority order:
    1. flush_i: pc_o<=new_pc_i; if_valid_o<=0, if_inst_o<=0, if_pc_o<=0; no count.
    2. stall_i: pc_o, if_* and fetch_cnt_o hold -> HOLD.
    3. branch_flag_i: capture (if_pc_o<=pc_o, if_inst_o<=inst_i, if_valid_o<=1, fetch_cnt_o+1) — this is the delay slot; pc_o<=branch_target_i.
    4. Otherwise: capture as above; pc_o<=pc_o+PC_STEP.
  - HOLD: ce_o stays 1, same address re-read.
    - flush_i wins as in RUN.
    - stall_i=1: remain HOLD.
    - stall_i=0: perform RUN actions 3/4 this edge -> RUN.
  - TRAP: feature only; see below.
- Branch sampled only when stall_i=0; ID holds branch_flag_i during stall.
- Priority on any edge: rst > flush_i > stall_i > branch_flag_i > sequential.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
- fetch_cnt_o: 32-bit, wraps FFFF_FFFF -> 0.
- rst asserted mid-operation (any state, incl. stall): all values return to reset values next edge; in-flight instruction discarded.
- flush_i during BOOT: ignored; BOOT always proceeds to RESET_PC.

Optional Feature:
- Macro FETCH_ALIGN_CHK_EN.
- Defined:
  - In RUN or HOLD, if selected redirect (new_pc_i on flush, branch_target_i on branch) has bits[1:0]!=0: pc_o held, if_valid_o<=0, align_exc_o<=1, ce_o<=0 -> TRAP.
  - TRAP: only flush_i with aligned new_pc_i exits: align_exc_o<=0, ce_o<=1, pc_o<=new_pc_i -> RUN.
  - Sequential increments are never checked.
- Undefined: no check; align_exc_o tied 0; bits[1:0] passed to pc_o unchanged (ROM ignores them); TRAP absent.

Test Plan:
- Reset release, no stall -> cycle1 ce_o=0; then pc_o=0,4,8,C; if_pc_o lags pc_o by one edge; fetch_cnt_o=1,2,3.
- stall_i high 3 cycles at pc_o=0x10 -> pc_o stays 0x10, if_pc_o stays 0xC, count frozen; release -> if_pc_o=0x10, pc_o=0x14.
- branch_flag_i=1, target 0x100, at pc_o=0x20 -> if_pc_o=0x20 (delay slot) valid, next pc_o=0x100, then 0x104.
- flush_i with new_pc_i=0x180 together with stall_i and branch_flag_i -> pc_o=0x180, if_valid_o=0, count unchanged.
- pc_o=0xFFFF_FFFC, no stall -> next pc_o=0x0; fetch_cnt_o preset near FFFF_FFFF wraps to 0.
- FETCH_ALIGN_CHK_EN, branch to 0x102 -> align_exc_o=1, ce_o=0; flush to 0x180 -> align_exc_o=0, pc_o=0x180. Without macro: pc_o=0x102, align_exc_o=0.
